// File: rtl/qnigma_tmr_arb.sv
// Multi-channel timeout scheduler: one shared prescaler and a one-channel-per-cycle decrement sweep.
// Optional periodic reload per channel is enabled by defining QNIGMA_TMR_ARB_RELOAD_EN.
module qnigma_tmr_arb #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TICKS    = 128,
  parameter int unsigned W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CHANNELS-1:0]   arm_val,
  output logic [CHANNELS-1:0]   arm_rdy,
  input  logic [CHANNELS*W-1:0] arm_tmo,
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
  input  logic [CHANNELS-1:0]   reload,
`endif
  input  logic [CHANNELS-1:0]   cancel,
  output logic [CHANNELS-1:0]   active,
  output logic [CHANNELS-1:0]   expire,
  output logic                  tick
);

  localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PW = (TICKS > 1) ? $clog2(TICKS) : 1;

  // The sweep must finish before the next prescaler wrap.
  if (TICKS <= CHANNELS + 1) begin : g_cfg_check
    $error("qnigma_tmr_arb: TICKS must be greater than CHANNELS+1");
  end

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] gnt_idx;
  logic [PW-1:0] pre;
  logic          wrap_c;
  logic          xfer_c;
  logic          visit_c;
  logic          found;
  int unsigned   cand;

  logic [W-1:0]  cnt [CHANNELS];
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
  logic [W-1:0]  rld_val [CHANNELS];
  logic [CHANNELS-1:0] rld;
`endif

  // Sweep starts on the same edge that raises tick, so channel i is visited i cycles after tick.
  assign wrap_c = en && (pre == PW'(TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap_c;
      if (wrap_c) begin
        pre <= '0;
      end else if (en) begin
        pre <= pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Round-robin grant in IDLE; sequential channel visits in SWEEP.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ptr_nxt   = ptr;
    arm_rdy   = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    cand      = 0;
    xfer_c    = 1'b0;
    visit_c   = 1'b0;
    case (state)
      IDLE: begin
        if (wrap_c) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end else if (rst) begin
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= CHANNELS) begin
              cand = cand - CHANNELS;
            end
            if (!found && arm_val[IW'(cand)]) begin
              found   = 1'b1;
              gnt_idx = IW'(cand);
            end
          end
          if (found) begin
            arm_rdy[gnt_idx] = 1'b1;
            xfer_c           = 1'b1;
            ptr_nxt          = (gnt_idx == IW'(CHANNELS - 1)) ? '0 : gnt_idx + IW'(1);
          end
        end
      end
      SWEEP: begin
        visit_c = 1'b1;
        if (idx == IW'(CHANNELS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Per-channel counters: arm beats cancel, cancel beats an expiring visit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= '0;
      expire <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
      rld <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        rld_val[i] <= '0;
      end
`endif
    end else begin
      expire <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (xfer_c && (gnt_idx == IW'(i))) begin
          cnt[i]    <= arm_tmo[i*W +: W];
          active[i] <= 1'b1;
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
          rld[i]     <= reload[i];
          rld_val[i] <= arm_tmo[i*W +: W];
`endif
        end else if (cancel[i]) begin
          active[i] <= 1'b0;
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
          rld[i] <= 1'b0;
`endif
        end else if (visit_c && (idx == IW'(i)) && active[i]) begin
          if (cnt[i] <= W'(1)) begin
            expire[i] <= 1'b1;
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
            if (rld[i]) begin
              cnt[i] <= rld_val[i];
            end else begin
              active[i] <= 1'b0;
            end
`else
            active[i] <= 1'b0;
`endif
          end else begin
            cnt[i] <= cnt[i] - W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qnigma_tmr_arb.sv
// Directed bench for qnigma_tmr_arb with CHANNELS=4, TICKS=8, W=16.
module tb_qnigma_tmr_arb;

  localparam int unsigned CH = 4;
  localparam int unsigned TK = 8;
  localparam int unsigned TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [CH-1:0]   arm_val;
  logic [CH-1:0]   arm_rdy;
  logic [CH*TW-1:0] arm_tmo;
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
  logic [CH-1:0]   reload;
`endif
  logic [CH-1:0]   cancel;
  logic [CH-1:0]   active;
  logic [CH-1:0]   expire;
  logic            tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qnigma_tmr_arb #(.CHANNELS(CH), .TICKS(TK), .W(TW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .arm_val (arm_val),
    .arm_rdy (arm_rdy),
    .arm_tmo (arm_tmo),
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
    .reload  (reload),
`endif
    .cancel  (cancel),
    .active  (active),
    .expire  (expire),
    .tick    (tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_tmo(input int ch, input logic [TW-1:0] v);
    arm_tmo[ch*TW +: TW] = v;
  endtask

  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = tick;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic arm_one(input int ch, input logic [TW-1:0] v);
    logic got;
    got = 1'b0;
    arm_val[ch] = 1'b1;
    set_tmo(ch, v);
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      got = arm_rdy[ch];
      if (!got) @(negedge clk);
    end
    chk("arm_one_grant", 32'(got), 1);
    @(negedge clk);
    arm_val[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH-1:0] acc;
    int nt, lt, kk;
    logic got;

    rst = 1'b0; en = 1'b1; arm_val = '0; cancel = '0; arm_tmo = '0;
`ifdef QNIGMA_TMR_ARB_RELOAD_EN
    reload = '0;
`endif
    repeat (2) cyc();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_expire", 32'(expire), 0);
    arm_val = 'hF;
    #1 chk("rst_rdy_gate", 32'(arm_rdy), 0);
    arm_val = '0;

    // Release between edges; tick rises on the 8th edge (9th cycle counting the release cycle).
    cyc();
    rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      chk("rst_first_tick", 32'(tick), (n == 8) ? 1 : 0);
    end

    // Contention: all four request from the first sweep on, pointer at 0.
    arm_tmo = {4{16'd100}};
    arm_val = 'hF;
    #1 chk("cont_sweep_rdy", 32'(arm_rdy), 0);
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("cont_sweep_rdy", 32'(arm_rdy), 0);
    end
    cyc();
    chk("cont_g0", 32'(arm_rdy), 'b0001);
    chk("cont_act0", 32'(active), 0);
    cyc();
    arm_val = 'b1110;
    #1 chk("cont_g1", 32'(arm_rdy), 'b0010);
    chk("cont_act1", 32'(active), 'b0001);
    cyc();
    arm_val = 'b1100;
    #1 chk("cont_g2", 32'(arm_rdy), 'b0100);
    cyc();
    arm_val = 'b1000;
    #1 chk("cont_wrap_rdy", 32'(arm_rdy), 0);
    cyc();
    chk("cont_tick2", 32'(tick), 1);
    chk("cont_sweep2_rdy", 32'(arm_rdy), 0);
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("cont_sweep2_rdy", 32'(arm_rdy), 0);
    end
    cyc();
    chk("cont_g3", 32'(arm_rdy), 'b1000);
    cyc();
    arm_val = '0;
    cancel = 'hF;
    chk("cont_all_active", 32'(active), 'hF);

    // Cancel all, then pointer back at 0 picks ch1 out of 4'b1010.
    cyc();
    cancel = '0;
    chk("cancel_all", 32'(active), 0);
    arm_val = 'b1010;
    set_tmo(1, 16'd1);
    #1 chk("ptr_at_zero", 32'(arm_rdy), 'b0010);
    cyc();
    arm_val = '0;
    chk("race_armed", 32'(active), 'b0010);
    cyc();
    chk("race_tick", 32'(tick), 1);
    cyc();
    cancel = 'b0010;
    cyc();
    cancel = '0;
    chk("race_no_expire", 32'(expire), 0);
    chk("race_inactive", 32'(active), 0);
    cyc();
    chk("race_no_expire_late", 32'(expire), 0);

    // Single arm: ch2 with 3; expires 3 cycles after the 3rd following tick.
    cyc();
    arm_val = 'b0100;
    set_tmo(2, 16'd3);
    #1 chk("single_grant", 32'(arm_rdy), 'b0100);
    cyc();
    arm_val = '0;
    chk("single_active", 32'(active), 'b0100);
    acc = '0; nt = 0;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      acc |= expire;
      if (tick) nt++;
    end
    chk("single_quiet", 32'(acc), 0);
    chk("single_ticks", 32'(nt), 3);
    cyc();
    chk("single_expire", 32'(expire), 'b0100);
    chk("single_drop", 32'(active), 0);
    cyc();
    chk("single_pulse_end", 32'(expire), 0);

    // Re-arm: ch0 with 5, re-armed with 2 after 4 ticks.
    arm_val = 'b0001;
    set_tmo(0, 16'd5);
    #1 chk("rearm_grant1", 32'(arm_rdy), 'b0001);
    cyc();
    arm_val = '0;
    acc = '0; nt = 0;
    for (int k = 1; k <= 31; k++) begin
      cyc();
      acc |= expire;
      if (tick) nt++;
    end
    chk("rearm_quiet", 32'(acc), 0);
    chk("rearm_ticks", 32'(nt), 4);
    arm_val = 'b0001;
    set_tmo(0, 16'd2);
    #1 chk("rearm_grant2", 32'(arm_rdy), 'b0001);
    cyc();
    arm_val = '0;
    acc = '0;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      acc |= expire;
    end
    chk("rearm_not_early", 32'(acc), 0);
    cyc();
    chk("rearm_expire", 32'(expire), 'b0001);

    // en gating: ch3 armed at 2, prescaler frozen for 50 cycles.
    repeat (3) cyc();
    arm_val = 'b1000;
    set_tmo(3, 16'd2);
    #1 chk("en_grant", 32'(arm_rdy), 'b1000);
    cyc();
    arm_val = '0;
    en = 1'b0;
    acc = '0; nt = 0;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      acc |= expire;
      if (tick) nt++;
    end
    chk("en_off_quiet", 32'(acc), 0);
    chk("en_off_ticks", 32'(nt), 0);
    chk("en_off_active", 32'(active), 'b1000);
    en = 1'b1;
    nt = 0; lt = 0; kk = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      cyc();
      if (tick) begin
        nt++;
        lt = k;
      end
      if (expire != '0) begin
        got = 1'b1;
        kk = k;
      end
    end
    chk("en_expire_seen", 32'(got), 1);
    chk("en_expire", 32'(expire), 'b1000);
    chk("en_ticks", 32'(nt), 2);
    chk("en_latency", 32'(kk - lt), 4);
    cyc();
    chk("en_pulse_end", 32'(expire), 0);
    chk("en_inactive", 32'(active), 0);

`ifdef QNIGMA_TMR_ARB_RELOAD_EN
    // Periodic ch3 with 2: one pulse every 2 ticks until cancelled.
    reload = 'b1000;
    arm_one(3, 16'd2);
    reload = '0;
    nt = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (expire == 'b1000) nt++;
    end
    chk("reload_pulses", 32'(nt), 2);
    chk("reload_active", 32'(active), 'b1000);
    cancel = 'b1000;
    cyc();
    cancel = '0;
    chk("reload_cancel", 32'(active), 0);
    acc = '0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      acc |= expire;
    end
    chk("reload_stopped", 32'(acc), 0);
`endif

    // Reset asserted mid-sweep clears everything without a clock edge.
    arm_one(0, 16'd100);
    wait_tick("mid_tick");
    chk("mid_active", 32'(active), 'b0001);
    arm_val = 'hF;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_expire", 32'(expire), 0);
    chk("mid_rst_rdy", 32'(arm_rdy), 0);
    arm_val = '0;
    cyc();
    rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      chk("mid_rst_first_tick", 32'(tick), (n == 8) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qnigma_tmr_arb.md
Name: qnigma_tmr_arb

Overview:
- Multi-channel timeout scheduler. One prescaler and one decrement datapath are shared among CHANNELS requesters, e.g. TCP retransmit, ARP/NDP and keepalive timers.
- Requesters arm a per-channel timeout, counted in base ticks. The block sweeps all channel counters once per base tick and pulses expire[i] when channel i's timeout elapses.
- Sits between the protocol FSMs and the stack core, replacing per-FSM private timers.

Parameters:
CHANNELS, 4, number of timer channels (>=2)
TICKS, 128, clock cycles per base tick; must satisfy TICKS > CHANNELS+1 (elaboration-time assertion)
W, 16, timeout counter width in base ticks

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
en  in  1  prescaler count enable
arm_val  in  CHANNELS  per-channel arm request
arm_rdy  out  CHANNELS  per-channel arm grant, one-hot or zero
arm_tmo  in  CHANNELS*W  timeout per channel; channel i uses slice [i*W +: W]
cancel  in  CHANNELS  per-channel cancel
active  out  CHANNELS  channel armed and counting
expire  out  CHANNELS  one-cycle expiry pulse
tick  out  1  one-cycle base-tick pulse

Behaviour:
- Reset (rst low, asynchronous):
  - prescaler counter=0, all channel counters=0.
  - active=0, expire=0, tick=0, arm_rdy=0.
  - FSM=IDLE, sweep index=0, round-robin pointer=0.
  - Deassertion is synchronised externally.
- Prescaler:
  - Counts 0..TICKS-1 while en=1 and wraps to 0.
  - tick is registered: 1 for the cycle after the counter equals TICKS-1 with en=1, otherwise 0.
  - en=0 freezes the counter and forces tick=0.
- FSM states: IDLE and SWEEP.
- IDLE:
  - If tick=1, go to SWEEP with index=0 and arm_rdy=0 that cycle.
  - Otherwise grant one arm request. The granted channel is the first i with arm_val[i]=1, searching from the round-robin pointer upward modulo CHANNELS.
  - arm_rdy[g] is combinational, same cycle as arm_val.
  - Transfer happens when arm_val[g] & arm_rdy[g]. On the next edge: cnt[g]=arm_tmo[g], active[g]=1, pointer=(g+1) mod CHANNELS.
  - Arming an already-active channel restarts it with the new value.
- SWEEP:
  - Visits one channel per cycle, index 0..CHANNELS-1, then returns to IDLE. Duration is exactly CHANNELS cycles.
  - arm_rdy=0 throughout SWEEP; arm_val must be held by the requester until granted.
  - Visiting channel i with active[i]=1 and cnt[i]<=1: on the next edge expire[i]=1 for one cycle and active[i]=0.
  - Visiting channel i with active[i]=1 and cnt[i]>1: cnt[i]=cnt[i]-1.
  - Inactive channels are untouched.
- Timing consequences:
  - arm_tmo=N with N>=1 expires on the Nth sweep after arming. arm_tmo=0 behaves as 1.
  - Expire latency after the triggering tick is (i+1) cycles for channel i.
- cancel[i]:
  - Accepted in any state; active[i]=0 on the next edge.
  - Same cycle as channel i's expiring visit: no expire pulse.
  - Same cycle as an arm transfer to channel i: the arm wins (channel re-armed).
- en deasserted mid-sweep: the sweep completes normally.
- Counter arithmetic is unsigned W bits. Decrement never wraps because of the <=1 expiry check.
- expire is a registered output with no combinational path from inputs. active is registered.

Optional Feature:
- Macro: QNIGMA_TMR_ARB_RELOAD_EN.
- Defined: adds input reload[CHANNELS], sampled at arm transfer and stored per channel with arm_tmo as the reload value. On an expiring visit with stored reload=1, expire[i] still pulses, but active[i] stays 1 and cnt[i] is reloaded, giving periodic operation. Cancel clears it.
- Undefined: no reload port or storage; every channel is one-shot.

Test Plan:
- Reset: CHANNELS=4, TICKS=8, rst low mid-sweep -> all outputs 0 immediately; after release, first tick occurs 9 cycles later with en held 1.
- Single arm: ch2 arm_tmo=3 -> expire[2] pulses 3 cycles after the 3rd tick following transfer; active[2] drops the same edge; no other expire.
- Contention: arm_val=4'b1111 held from IDLE with pointer 0 -> grants in order ch0,1,2,3 on consecutive IDLE cycles; no grant during SWEEP cycles; pointer ends at 0.
- Cancel race: ch1 arm_tmo=1, cancel[1] asserted on ch1's visit cycle -> no expire[1], active[1]=0.
- Re-arm: ch0 armed with 5, re-armed with 2 after 4 ticks -> expire after 2 further ticks, not 1.
- en gating: en=0 for 50 cycles with ch3 armed at 2 -> no tick, no expire; on en=1, expire[3] follows the 2nd tick. With QNIGMA_TMR_ARB_RELOAD_EN defined and reload=1, arm_tmo=2 -> expire[3] every 2 ticks until cancel.
